// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;
    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [31:0]     instr_t;
    typedef logic [4:0]      r_t;

    localparam instr_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/if_fetch_unit_fetch_out_slot.sv
// One-entry output buffer between instruction memory and IF/ID.
// Priority at the edge: clear, then load, then drain.
module fetch_out_slot
    import if_fetch_unit_pkg::*;
#(
    parameter int     W         = XLEN,
    parameter instr_t NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_pc_i,
    input  instr_t       load_instr_i,
    input  logic         drain_i,
    output logic         valid_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc_p4_o,
    output instr_t       instr_o,
    output r_t           rd_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] pc_q, pc_d;
    instr_t       instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            instr_d = load_instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc_p4_o = pc_q + W'(4);
    assign instr_o = valid_q ? instr_q : NOP_INSTR;
    assign rd_o    = instr_o[11:7];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in
// flight, and squashes it on a redirect via the kill flag.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          XLEN      = if_fetch_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter instr_t      NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  instr_t          imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_p4_out,
    output instr_t          instr_out,
    output r_t              rd_out,
    output logic            valid_out,
    output logic            flush_out
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            req_fire, resp_fire, slot_load, slot_drain;

    assign req_fire   = imem_req && imem_ack;
    assign resp_fire  = (state_q == WAIT) && imem_rvalid;
    assign slot_load  = resp_fire && !kill_q && !redirect_valid;
    assign slot_drain = valid_out && !stall;
    assign flush_out  = redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        if (req_fire) begin
            req_pc_d = fetch_pc_q;
            state_d  = WAIT;
        end
        if (resp_fire) begin
            state_d = REQ;
            kill_d  = 1'b0;
            if (!kill_q) fetch_pc_d = req_pc_q + XLEN'(4);
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // An outstanding response that has not arrived yet must be dropped later.
            if (req_fire || ((state_q == WAIT) && !imem_rvalid)) begin
                kill_d  = 1'b1;
                state_d = WAIT;
            end
        end
    end

    always_comb begin
        imem_req  = (state_q == REQ) && (!valid_out || !stall) && !rst;
        imem_addr = fetch_pc_q;
    end

    fetch_out_slot #(
        .W         (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (redirect_valid),
        .load_i       (slot_load),
        .load_pc_i    (req_pc_q),
        .load_instr_i (imem_rdata),
        .drain_i      (slot_drain),
        .valid_o      (valid_out),
        .pc_o         (pc_out),
        .pc_p4_o      (pc_p4_out),
        .instr_o      (instr_out),
        .rd_o         (rd_out)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; the bench plays instruction memory.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid, imem_ack, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_out, flush_out;
    logic [31:0] imem_addr, pc_out, pc_p4_out, instr_out;
    logic [4:0]  rd_out;

    int n_chk = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .pc_p4_out(pc_p4_out), .instr_out(instr_out),
        .rd_out(rd_out), .valid_out(valid_out), .flush_out(flush_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [4:0] rd);
        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".pc4"}, pc_p4_out, pc + 32'd4);
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
    endtask

    // Caller is at edge+1ns in REQ with stall low; ack now, data next cycle.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] w);
        imem_ack = 1'b1;
        #1;
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_addr, addr);
        tick();
        imem_ack = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = w;
        #1;
        chk({tag, ".wait_req"}, {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) tick();
        #1;
        chk("rst.valid", {31'd0, valid_out}, 32'd0);
        chk("rst.pc", pc_out, 32'h0);
        chk("rst.pc4", pc_p4_out, 32'h4);
        chk("rst.instr", instr_out, 32'h0000_0013);
        chk("rst.rd", {27'd0, rd_out}, 32'd0);
        chk("rst.req", {31'd0, imem_req}, 32'd0);

        // Streaming fetch from reset
        tick();
        rst = 1'b0;
        fetch_one("f0", 32'h0, 32'h0050_0093);
        chk_slot("s0", 32'h0, 32'h0050_0093, 5'd1);
        fetch_one("f1", 32'h4, 32'h00A0_0113);
        chk_slot("s1", 32'h4, 32'h00A0_0113, 5'd2);
        fetch_one("f2", 32'h8, 32'h00F0_0193);
        chk_slot("s2", 32'h8, 32'h00F0_0193, 5'd3);

        // Stall holds the slot and blocks new requests
        stall = 1'b1;
        #1;
        chk("stall.req0", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.req", {31'd0, imem_req}, 32'd0);
            chk_slot("stall", 32'h8, 32'h00F0_0193, 5'd3);
        end
        stall = 1'b0;
        #1;
        chk("unstall.req", {31'd0, imem_req}, 32'd1);
        chk("unstall.addr", imem_addr, 32'hC);
        fetch_one("f3", 32'hC, 32'h0010_0213);
        chk_slot("s3", 32'hC, 32'h0010_0213, 5'd4);

        // Redirect while waiting for data
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("rw.flush", {31'd0, flush_out}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rw.valid", {31'd0, valid_out}, 32'd0);
        chk("rw.flush0", {31'd0, flush_out}, 32'd0);
        chk("rw.req_killwait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0FF0_0F93;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("rw.drop", {31'd0, valid_out}, 32'd0);
        fetch_one("rw.f", 32'h100, 32'h0020_0293);
        chk_slot("rw.s", 32'h100, 32'h0020_0293, 5'd5);

        // Redirect to unaligned target in the ack cycle
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("ra.addr", imem_addr, 32'h104);
        chk("ra.flush", {31'd0, flush_out}, 32'd1);
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0FF0_0F93;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("ra.drop", {31'd0, valid_out}, 32'd0);
        fetch_one("ra.f", 32'h100, 32'h0030_0313);
        chk_slot("ra.s", 32'h100, 32'h0030_0313, 5'd6);

        // Reset in the middle of WAIT, stale data afterwards
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("rm.valid", {31'd0, valid_out}, 32'd0);
        chk("rm.pc", pc_out, 32'h0);
        chk("rm.instr", instr_out, 32'h0000_0013);
        chk("rm.req", {31'd0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0FF0_0F93;
        #1;
        chk("rm.req1", {31'd0, imem_req}, 32'd1);
        chk("rm.addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("rm.stale", {31'd0, valid_out}, 32'd0);
        fetch_one("rm.f", 32'h0, 32'h0040_0393);
        chk_slot("rm.s", 32'h0, 32'h0040_0393, 5'd7);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        fetch_one("wr.f", 32'hFFFF_FFFC, 32'h0050_0413);
        chk("wr.pc", pc_out, 32'hFFFF_FFFC);
        chk("wr.pc4", pc_p4_out, 32'h0);
        chk("wr.rd", {27'd0, rd_out}, 32'd8);
        chk("wr.req", {31'd0, imem_req}, 32'd1);
        chk("wr.addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
